// File: rtl/piece_fall_ctrl.sv
// Falling-cell controller for a 10x20 well: gravity on frame ticks, keyboard
// moves and drops, per-column stack heights, lock/respawn and game-over.
module piece_fall_ctrl #(
  parameter int GRID_X0        = 200,
  parameter int CELL           = 24,
  parameter int COLS           = 10,
  parameter int ROWS           = 20,
  parameter int SPAWN_COL      = 4,
  parameter int GRAVITY_FRAMES = 30
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_size,
  output logic       lock_valid,
  output logic [3:0] lock_col,
  output logic [4:0] lock_row,
  output logic       game_over
);

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  localparam logic [3:0] SPAWN_COL_L = 4'(SPAWN_COL);
  localparam logic [3:0] LAST_COL_L  = 4'(COLS - 1);
  localparam logic [4:0] ROWS_L      = 5'(ROWS);
  localparam logic [4:0] LAST_ROW_L  = 5'(ROWS - 1);
  localparam logic [4:0] GRAV_LAST_L = 5'(GRAVITY_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_SPAWN = 2'd0,
    ST_FALL  = 2'd1,
    ST_LOCK  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t     state_r, state_s;
  logic [3:0] col_r, col_s, col_mv_s, col_left_s, col_right_s;
  logic [4:0] row_r, row_s;
  logic [4:0] grav_r, grav_s;
  logic [7:0] prev_key_r;
  logic [4:0] heights_r [COLS];
  logic       heights_inc_s, heights_clr_s, step_s;
  logic       key_new_s, edge_a_s, edge_d_s, edge_space_s, edge_enter_s, s_held_s;

  // Cell at `row` is inside the stack of a column whose height is `h`.
  function automatic logic occupied(input logic [4:0] row, input logic [4:0] h);
    return row >= (ROWS_L - h);
  endfunction

  // Lowest free row of a column; only evaluated for columns that are not full.
  function automatic logic [4:0] land(input logic [4:0] h);
    return LAST_ROW_L - h;
  endfunction

  assign key_new_s    = frame_tick && (keycode != prev_key_r);
  assign edge_a_s     = key_new_s && (keycode == KEY_A);
  assign edge_d_s     = key_new_s && (keycode == KEY_D);
  assign edge_space_s = key_new_s && (keycode == KEY_SPACE);
  assign edge_enter_s = key_new_s && (keycode == KEY_ENTER);
  assign s_held_s     = (keycode == KEY_S);
  // Neighbour indices are clamped so the heights lookup never leaves the array.
  assign col_left_s   = (col_r == 4'd0) ? col_r : col_r - 4'd1;
  assign col_right_s  = (col_r == LAST_COL_L) ? col_r : col_r + 4'd1;

  // Next-state and datapath decisions for the piece.
  always_comb begin
    state_s       = state_r;
    col_s         = col_r;
    row_s         = row_r;
    grav_s        = grav_r;
    col_mv_s      = col_r;
    step_s        = 1'b0;
    heights_inc_s = 1'b0;
    heights_clr_s = 1'b0;
    case (state_r)
      ST_SPAWN: begin
        col_s  = SPAWN_COL_L;
        row_s  = 5'd0;
        grav_s = 5'd0;
        if (heights_r[SPAWN_COL] == ROWS_L) state_s = ST_OVER;
        else                                state_s = ST_FALL;
      end
      ST_FALL: begin
        if (!frame_tick) begin
          state_s = ST_FALL;
        end else if (edge_space_s) begin
          row_s   = land(heights_r[col_r]);
          state_s = ST_LOCK;
        end else begin
          // D is checked first so it wins over A.
          if (edge_d_s) begin
            if (col_r != LAST_COL_L && !occupied(row_r, heights_r[col_right_s])) col_mv_s = col_right_s;
            else col_mv_s = col_r;
          end else if (edge_a_s) begin
            if (col_r != 4'd0 && !occupied(row_r, heights_r[col_left_s])) col_mv_s = col_left_s;
            else col_mv_s = col_r;
          end else begin
            col_mv_s = col_r;
          end
          col_s  = col_mv_s;
          step_s = s_held_s || (grav_r == GRAV_LAST_L);
          grav_s = step_s ? 5'd0 : grav_r + 5'd1;
          if (step_s && row_r == land(heights_r[col_mv_s])) state_s = ST_LOCK;
          else if (step_s)                                  row_s   = row_r + 5'd1;
          else                                              row_s   = row_r;
        end
      end
      ST_LOCK: begin
        heights_inc_s = 1'b1;
        state_s       = ST_SPAWN;
      end
      ST_OVER: begin
        if (edge_enter_s) begin
          heights_clr_s = 1'b1;
          state_s       = ST_SPAWN;
        end else begin
          state_s = ST_OVER;
        end
      end
      default: state_s = ST_SPAWN;
    endcase
  end

  // Piece position, gravity counter and FSM state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_SPAWN;
      col_r   <= SPAWN_COL_L;
      row_r   <= 5'd0;
      grav_r  <= 5'd0;
    end else begin
      state_r <= state_s;
      col_r   <= col_s;
      row_r   <= row_s;
      grav_r  <= grav_s;
    end
  end

  // Key history for press-edge detection, sampled once per frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)        prev_key_r <= 8'h00;
    else if (frame_tick) prev_key_r <= keycode;
    else                 prev_key_r <= prev_key_r;
  end

  // Column stack heights; saturate at ROWS.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < COLS; i++) heights_r[i] <= 5'd0;
    end else if (heights_clr_s) begin
      for (int i = 0; i < COLS; i++) heights_r[i] <= 5'd0;
    end else if (heights_inc_s && heights_r[col_r] != ROWS_L) begin
      heights_r[col_r] <= heights_r[col_r] + 5'd1;
    end else begin
      heights_r[col_r] <= heights_r[col_r];
    end
  end

  assign BallX      = 10'(GRID_X0) + {6'd0, col_r} * 10'(CELL) + 10'(CELL / 2);
  assign BallY      = {5'd0, row_r} * 10'(CELL) + 10'(CELL / 2);
  assign Ball_size  = 10'(CELL / 2);
  assign lock_valid = (state_r == ST_LOCK);
  assign lock_col   = col_r;
  assign lock_row   = row_r;
  assign game_over  = (state_r == ST_OVER);

endmodule

// File: tb/tb_piece_fall_ctrl.sv
// Directed bench for piece_fall_ctrl: vector table for moves and drops, plus
// hand sequences for gravity, stacking/game over, blocking and mid-lock reset.
module tb_piece_fall_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] BallX, BallY, Ball_size;
  logic       lock_valid, game_over;
  logic [3:0] lock_col;
  logic [4:0] lock_row;

  piece_fall_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .keycode(keycode),
    .BallX(BallX), .BallY(BallY), .Ball_size(Ball_size),
    .lock_valid(lock_valid), .lock_col(lock_col), .lock_row(lock_row),
    .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic [7:0] key;
    logic [9:0] x;
    logic [9:0] y;
    logic       lk;
    logic [3:0] lc;
    logic [4:0] lr;
    logic       ov;
  } vec_t;

  vec_t       vecs[$];
  int         errors = 0;
  int         checks = 0;
  logic       seen;
  logic [3:0] cap_c;
  logic [4:0] cap_r;
  int         n;

  function automatic vec_t mk(input logic r, input logic [7:0] k, input int x, input int y,
                              input logic lk, input int lc, input int lr, input logic ov);
    vec_t v;
    v.rst = r; v.key = k; v.x = 10'(x); v.y = 10'(y);
    v.lk = lk; v.lc = 4'(lc); v.lr = 5'(lr); v.ov = ov;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    Reset_n = 1'b0; keycode = 8'h00; frame_tick = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // One frame tick with key k, then watch four cycles for a lock pulse.
  task automatic do_tick(input logic [7:0] k);
    @(negedge Clk); keycode = k; frame_tick = 1'b1;
    @(negedge Clk); frame_tick = 1'b0;
    seen = 1'b0; cap_c = 4'd0; cap_r = 5'd0;
    repeat (4) begin
      if (lock_valid === 1'b1) begin seen = 1'b1; cap_c = lock_col; cap_r = lock_row; end
      @(negedge Clk);
    end
  endtask

  initial begin
    // Group 1: D held then repeated presses, clamp at column 9.
    vecs.push_back(mk(1'b1, 8'h07, 332, 12, 1'b0, 0, 0, 1'b0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1'b0, 8'h07, 332, 12, 1'b0, 0, 0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 332, 12, 1'b0, 0, 0, 1'b0));
    for (int i = 0; i < 6; i++) begin
      vecs.push_back(mk(1'b0, 8'h07, (i < 4) ? 356 + 24 * i : 428, 12, 1'b0, 0, 0, 1'b0));
      vecs.push_back(mk(1'b0, 8'h00, (i < 4) ? 356 + 24 * i : 428, 12, 1'b0, 0, 0, 1'b0));
    end
    // Group 2: hard drops stack col 4, A moves clamp at column 0, drop there.
    vecs.push_back(mk(1'b1, 8'h2C, 308, 12, 1'b1, 4, 19, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 308, 12, 1'b0, 0, 0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h2C, 308, 12, 1'b1, 4, 18, 1'b0));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(1'b0, 8'h00, (i == 0) ? 308 : 308 - 24 * i, 12, 1'b0, 0, 0, 1'b0));
      vecs.push_back(mk(1'b0, 8'h04, (i < 4) ? 284 - 24 * i : 212, 12, 1'b0, 0, 0, 1'b0));
    end
    vecs.push_back(mk(1'b0, 8'h2C, 308, 12, 1'b1, 0, 19, 1'b0));

    // Reset values, checked while reset is held.
    Reset_n = 1'b0;
    #12;
    check("reset_out", {BallX, BallY, lock_valid, game_over}, {10'd308, 10'd12, 1'b0, 1'b0});
    check("ball_size", {22'd0, Ball_size}, 32'd12);
    @(negedge Clk); Reset_n = 1'b1;

    // Gravity: one row per 30 ticks, counter restarts after each step.
    for (int t = 1; t <= 60; t++) begin
      do_tick(8'h00);
      check($sformatf("gravity_t%0d", t), {22'd0, BallY}, 32'(12 + 24 * (t / 30)));
    end

    foreach (vecs[i]) begin
      if (vecs[i].rst) apply_reset();
      do_tick(vecs[i].key);
      check($sformatf("vec%0d_k%02h", i, vecs[i].key),
            {1'b0, BallX, BallY, seen, cap_c, cap_r, game_over},
            {1'b0, vecs[i].x, vecs[i].y, vecs[i].lk, vecs[i].lc, vecs[i].lr, vecs[i].ov});
    end

    // Fill column 4 to the top, then game over and restart with Enter.
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      do_tick(8'h2C);
      check($sformatf("stack_lock%0d", i), {23'd0, seen, cap_c, cap_r}, {23'd0, 1'b1, 4'd4, 5'(19 - i)});
      if (i == 18) check("not_over_at_19", {31'd0, game_over}, 32'd0);
      do_tick(8'h00);
    end
    check("over_set", {11'd0, game_over, BallX, BallY}, {11'd0, 1'b1, 10'd308, 10'd12});
    do_tick(8'h07);
    check("over_ignores_d", {11'd0, game_over, BallX, BallY}, {11'd0, 1'b1, 10'd308, 10'd12});
    do_tick(8'h00);
    do_tick(8'h28);
    check("enter_restart", {11'd0, game_over, BallX, BallY}, {11'd0, 1'b0, 10'd308, 10'd12});
    do_tick(8'h2C);
    check("heights_cleared", {23'd0, seen, cap_c, cap_r}, {23'd0, 1'b1, 4'd4, 5'd19});

    // Blocked move into a full column, then soft drop onto a height-2 stack.
    apply_reset();
    do_tick(8'h2C); do_tick(8'h00); do_tick(8'h2C);
    for (int i = 0; i < 20; i++) begin
      do_tick(8'h07);
      do_tick(8'h2C);
      check($sformatf("col5_lock%0d", i), {23'd0, seen, cap_c, cap_r}, {23'd0, 1'b1, 4'd5, 5'(19 - i)});
    end
    repeat (3) do_tick(8'h16);
    check("soft_row3", {22'd0, BallY}, 32'd84);
    do_tick(8'h07);
    check("d_blocked", {12'd0, BallX, BallY}, {12'd0, 10'd308, 10'd84});
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      do_tick(8'h16);
      n++;
    end
    check("soft_land", {23'd0, seen, cap_c, cap_r}, {23'd0, 1'b1, 4'd4, 5'd17});
    check("soft_ticks", 32'(n), 32'd15);

    // Reset asserted while in LOCK.
    apply_reset();
    do_tick(8'h2C); do_tick(8'h00);
    @(negedge Clk); keycode = 8'h2C; frame_tick = 1'b1;
    @(negedge Clk); frame_tick = 1'b0;
    check("lock_before_rst", {31'd0, lock_valid}, 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("rst_mid_lock", {10'd0, lock_valid, game_over, BallX, BallY}, {10'd0, 1'b0, 1'b0, 10'd308, 10'd12});
    @(negedge Clk); Reset_n = 1'b1; keycode = 8'h00;
    @(negedge Clk);
    check("no_pulse_after_rst", {31'd0, lock_valid}, 32'd0);
    do_tick(8'h2C);
    check("rst_heights_clear", {23'd0, seen, cap_c, cap_r}, {23'd0, 1'b1, 4'd4, 5'd19});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
